// File: rtl/ps2_cursor_tracker.sv
// Turns decoded PS/2 mouse packets into clamped absolute cursor coordinates and button state.
// Optional build macro CURSOR_ACCEL_EN doubles any delta whose magnitude exceeds ACCEL_THRESH.
module ps2_cursor_tracker #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int COORD_W      = 10,
  parameter int SPEED_SHIFT  = 0,
  parameter int ACCEL_THRESH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic [7:0]         pkt_status,
  input  logic [7:0]         pkt_x,
  input  logic [7:0]         pkt_y,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               left_button,
  output logic               right_button,
  output logic               middle_button,
  output logic               left_press,
  output logic               right_press,
  output logic               cursor_update,
  output logic               sync_error
);

`ifdef CURSOR_ACCEL_EN
  localparam int IW = COORD_W + SPEED_SHIFT + 4;
`else
  localparam int IW = COORD_W + SPEED_SHIFT + 3;
`endif

  localparam logic signed [IW-1:0] X_MAX = IW'(SCREEN_W - 1);
  localparam logic signed [IW-1:0] Y_MAX = IW'(SCREEN_H - 1);
  localparam logic signed [IW-1:0] ACC_T = IW'(ACCEL_THRESH);

  typedef enum logic [1:0] {IDLE, SCALE, CLAMP, COMMIT} state_t;

  state_t state_reg, state_next;

  logic [7:0]         status_reg, x_reg, y_reg;
  logic signed [IW-1:0] delta_reg [2];
  logic signed [IW-1:0] delta_next [2];
  logic [COORD_W-1:0] nx_reg, ny_reg;
  logic [COORD_W-1:0] cursor_x_reg, cursor_y_reg;
  logic               left_reg, right_reg, middle_reg;
  logic               left_press_reg, right_press_reg;
  logic               update_reg, sync_err_reg;
  logic               accept, commit_ok, commit_drop;
  logic [1:0][8:0]    raw_delta;
  logic [1:0]         axis_ovf;
  logic signed [IW-1:0] sum_x, sum_y;

  function automatic logic signed [IW-1:0] scale_delta(input logic [8:0] raw, input logic ovf);
    logic signed [IW-1:0] ext;
    logic signed [IW-1:0] acc;
    ext = ovf ? '0 : {{(IW-9){raw[8]}}, raw};
`ifdef CURSOR_ACCEL_EN
    acc = (ext > ACC_T || ext < -ACC_T) ? (ext <<< 1) : ext;
`else
    acc = ext;
`endif
    return acc <<< SPEED_SHIFT;
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [IW-1:0] v,
                                                     input logic signed [IW-1:0] vmax);
    logic [COORD_W-1:0] r;
    if (v < 0)
      r = '0;
    else if (v > vmax)
      r = vmax[COORD_W-1:0];
    else
      r = v[COORD_W-1:0];
    return r;
  endfunction

  // Axis 0 is X, axis 1 is Y; each carries its own sign and overflow bit.
  assign raw_delta[0] = {status_reg[4], x_reg};
  assign raw_delta[1] = {status_reg[5], y_reg};
  assign axis_ovf     = status_reg[7:6];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      assign delta_next[gi] = scale_delta(raw_delta[gi], axis_ovf[gi]);
    end
  endgenerate

  // PS/2 reports up as positive while screen rows grow downward.
  assign sum_x = $signed({{(IW-COORD_W){1'b0}}, cursor_x_reg}) + delta_reg[0];
  assign sum_y = $signed({{(IW-COORD_W){1'b0}}, cursor_y_reg}) - delta_reg[1];

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pkt_valid) state_next = SCALE;
      SCALE:   state_next = CLAMP;
      CLAMP:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pkt_ready   = (state_reg == IDLE);
    accept      = pkt_ready && pkt_valid;
    commit_ok   = (state_reg == COMMIT) && status_reg[3];
    commit_drop = (state_reg == COMMIT) && !status_reg[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_reg      <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      delta_reg[0]    <= '0;
      delta_reg[1]    <= '0;
      nx_reg          <= '0;
      ny_reg          <= '0;
      cursor_x_reg    <= COORD_W'(SCREEN_W / 2);
      cursor_y_reg    <= COORD_W'(SCREEN_H / 2);
      left_reg        <= 1'b0;
      right_reg       <= 1'b0;
      middle_reg      <= 1'b0;
      left_press_reg  <= 1'b0;
      right_press_reg <= 1'b0;
      update_reg      <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        status_reg <= pkt_status;
        x_reg      <= pkt_x;
        y_reg      <= pkt_y;
      end
      if (state_reg == SCALE) begin
        delta_reg[0] <= delta_next[0];
        delta_reg[1] <= delta_next[1];
      end
      if (state_reg == CLAMP) begin
        nx_reg <= clamp_coord(sum_x, X_MAX);
        ny_reg <= clamp_coord(sum_y, Y_MAX);
      end
      if (commit_ok) begin
        cursor_x_reg <= nx_reg;
        cursor_y_reg <= ny_reg;
        left_reg     <= status_reg[0];
        right_reg    <= status_reg[1];
        middle_reg   <= status_reg[2];
      end
      left_press_reg  <= commit_ok && status_reg[0] && !left_reg;
      right_press_reg <= commit_ok && status_reg[1] && !right_reg;
      update_reg      <= commit_ok;
      sync_err_reg    <= commit_drop;
    end
  end

  assign cursor_x      = cursor_x_reg;
  assign cursor_y      = cursor_y_reg;
  assign left_button   = left_reg;
  assign right_button  = right_reg;
  assign middle_button = middle_reg;
  assign left_press    = left_press_reg;
  assign right_press   = right_press_reg;
  assign cursor_update = update_reg;
  assign sync_error    = sync_err_reg;

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Directed bench for ps2_cursor_tracker: hand-computed cursor, button and pulse expectations.
module tb_ps2_cursor_tracker;
  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] pkt_status, pkt_x, pkt_y;
  logic [9:0] cursor_x, cursor_y;
  logic       left_button, right_button, middle_button;
  logic       left_press, right_press, cursor_update, sync_error;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ps2_cursor_tracker dut (
    .clk(clk), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_status(pkt_status), .pkt_x(pkt_x), .pkt_y(pkt_y),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .left_button(left_button), .right_button(right_button), .middle_button(middle_button),
    .left_press(left_press), .right_press(right_press),
    .cursor_update(cursor_update), .sync_error(sync_error)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pkt_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Sends one packet and checks the 4-cycle handshake, then the committed outputs after E3.
  task automatic send(input string tag, input logic [7:0] s, input logic [7:0] x, input logic [7:0] y,
                      input int ex, input int ey, input int upd, input int serr,
                      input int lb, input int rb, input int mb, input int lp, input int rp);
    @(negedge clk);
    chk({tag, ".idle_ready"}, pkt_ready, 1);
    chk({tag, ".idle_upd"}, cursor_update, 0);
    chk({tag, ".idle_sync"}, sync_error, 0);
    pkt_valid = 1'b1; pkt_status = s; pkt_x = x; pkt_y = y;
    @(posedge clk);
    #1 pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, ".busy_ready"}, pkt_ready, 0);
    end
    @(negedge clk);
    chk({tag, ".ready"}, pkt_ready, 1);
    chk({tag, ".x"}, cursor_x, ex);
    chk({tag, ".y"}, cursor_y, ey);
    chk({tag, ".upd"}, cursor_update, upd);
    chk({tag, ".sync"}, sync_error, serr);
    chk({tag, ".lb"}, left_button, lb);
    chk({tag, ".rb"}, right_button, rb);
    chk({tag, ".mb"}, middle_button, mb);
    chk({tag, ".lp"}, left_press, lp);
    chk({tag, ".rp"}, right_press, rp);
    $display("txn %s status=%02h x=%02h y=%02h -> cursor=(%0d,%0d) upd=%0d sync=%0d",
             tag, s, x, y, cursor_x, cursor_y, cursor_update, sync_error);
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; pkt_status = '0; pkt_x = '0; pkt_y = '0;
    do_reset();
    @(negedge clk);
    chk("rst.x", cursor_x, 320);
    chk("rst.y", cursor_y, 240);
    chk("rst.ready", pkt_ready, 1);
    chk("rst.buttons", {left_button, right_button, middle_button}, 0);
    chk("rst.pulses", {left_press, right_press, cursor_update, sync_error}, 0);

    send("basic", 8'h08, 8'h05, 8'h03, 325, 237, 1, 0, 0, 0, 0, 0, 0);

    do_reset();
    send("xneg1", 8'h18, 8'h00, 8'h00, 64, 240, 1, 0, 0, 0, 0, 0, 0);
    send("xneg2", 8'h18, 8'h00, 8'h00, 0, 240, 1, 0, 0, 0, 0, 0, 0);
    send("xneg3", 8'h18, 8'h00, 8'h00, 0, 240, 1, 0, 0, 0, 0, 0, 0);
    send("yneg1", 8'h28, 8'h00, 8'h00, 0, 479, 1, 0, 0, 0, 0, 0, 0);
    send("yneg2", 8'h28, 8'h00, 8'h00, 0, 479, 1, 0, 0, 0, 0, 0, 0);
    send("xovf", 8'h48, 8'h7F, 8'h02, 0, 477, 1, 0, 0, 0, 0, 0, 0);
    send("nosync", 8'h00, 8'h05, 8'h05, 0, 477, 0, 1, 0, 0, 0, 0, 0);

    send("left1", 8'h09, 8'h00, 8'h00, 0, 477, 1, 0, 1, 0, 0, 1, 0);
    send("left2", 8'h09, 8'h00, 8'h00, 0, 477, 1, 0, 1, 0, 0, 0, 0);
    send("left3", 8'h08, 8'h00, 8'h00, 0, 477, 1, 0, 0, 0, 0, 0, 0);
    send("right1", 8'h0A, 8'h03, 8'h00, 3, 477, 1, 0, 0, 1, 0, 0, 1);
    send("rmid", 8'h0E, 8'h00, 8'h00, 3, 477, 1, 0, 0, 1, 1, 0, 0);

    // pkt_valid held high across two packets: second acceptance lands on E4.
    @(negedge clk);
    pkt_valid = 1'b1; pkt_status = 8'h08; pkt_x = 8'h01; pkt_y = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("b2b.busy1", pkt_ready, 0);
    end
    @(negedge clk);
    chk("b2b.ready_e3", pkt_ready, 1);
    chk("b2b.x1", cursor_x, 4);
    chk("b2b.upd1", cursor_update, 1);
    @(negedge clk);
    chk("b2b.accept_e4", pkt_ready, 0);
    pkt_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b.busy2", pkt_ready, 0);
    @(negedge clk);
    chk("b2b.x2", cursor_x, 5);
    chk("b2b.upd2", cursor_update, 1);
    $display("txn b2b -> cursor=(%0d,%0d)", cursor_x, cursor_y);

    // Reset while the packet sits in CLAMP discards it.
    @(negedge clk);
    pkt_valid = 1'b1; pkt_status = 8'h09; pkt_x = 8'h10; pkt_y = 8'h10;
    @(posedge clk);
    #1 pkt_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstclamp.x", cursor_x, 320);
    chk("rstclamp.y", cursor_y, 240);
    chk("rstclamp.ready", pkt_ready, 1);
    chk("rstclamp.upd", cursor_update, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rstclamp.quiet", {cursor_update, sync_error, left_button}, 0);
    end
    chk("rstclamp.x_hold", cursor_x, 320);
    $display("txn rst_in_clamp -> cursor=(%0d,%0d)", cursor_x, cursor_y);

`ifdef CURSOR_ACCEL_EN
    send("accel16", 8'h08, 8'h10, 8'h00, 352, 240, 1, 0, 0, 0, 0, 0, 0);
    send("accel8", 8'h08, 8'h08, 8'h00, 360, 240, 1, 0, 0, 0, 0, 0, 0);
`else
    send("plain16", 8'h08, 8'h10, 8'h00, 336, 240, 1, 0, 0, 0, 0, 0, 0);
    send("plain8", 8'h08, 8'h08, 8'h00, 344, 240, 1, 0, 0, 0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
